// File: rtl/relu_maxpool_stream_pkg.sv
// Shared helpers for the streaming ReLU + max-pool stage: default width,
// a width helper for counters/indices, and the signed compare used for max.
package relu_maxpool_stream_pkg;

  localparam int DW_DEF = 16;

  // Bits needed to index n items; never less than 1 so ports stay legal.
  function automatic int clog2w(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

  // Max select: 1 when a should win over b (signed, ties keep a).
  function automatic logic smax_sel(input logic signed [63:0] a, input logic signed [63:0] b);
    return a >= b;
  endfunction

endpackage

// File: rtl/relu_maxpool_stream_lane.sv
// One channel of the pooler: ReLU, the row of partial maxima and the
// compare that either starts a window or folds a pixel into it.
module pool_max_lane
  import relu_maxpool_stream_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int NP      = 2,
  parameter int PW      = 1,
  parameter bit RELU_EN = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_wr,
  input  logic          i_start,
  input  logic          i_emit,
  input  logic [PW-1:0] i_p,
  input  logic [DW-1:0] i_x,
  output logic [DW-1:0] o_data
);

  logic [NP-1:0][DW-1:0] part;
  logic signed [DW-1:0]  xr, cur, m;

  assign xr  = (RELU_EN && i_x[DW-1]) ? '0 : i_x;
  assign cur = part[i_p];
  // First pixel of a window overwrites, so no per-window clear is needed.
  assign m   = (i_start || smax_sel(64'(xr), 64'(cur))) ? xr : cur;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      part   <= '0;
      o_data <= '0;
    end else if (i_clear) begin
      part   <= '0;
    end else begin
      if (i_wr)   part[i_p] <= m;
      if (i_emit) o_data    <= m;
    end
  end

endmodule

// File: rtl/relu_maxpool_stream.sv
// Streaming ReLU + POOLxPOOL max-pool over a raster pixel stream; one row of
// partials per channel, pooled result one cycle after the window completes.
module relu_maxpool_stream
  import relu_maxpool_stream_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int OUT_SIZE = 4,
  parameter int POOL     = 2,
  parameter int CHANNELS = 1,
  parameter bit RELU_EN  = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  input  logic                     i_valid,
  input  logic [CHANNELS*DW-1:0]   i_data,
  output logic                     o_valid,
  output logic [CHANNELS*DW-1:0]   o_data,
  output logic [clog2w((OUT_SIZE/POOL)*(OUT_SIZE/POOL))-1:0] o_idx,
  output logic                     o_frame_done
);

  localparam int NP = OUT_SIZE / POOL;
  localparam int CW = clog2w(OUT_SIZE);
  localparam int PW = clog2w(NP);
  localparam int IW = clog2w(NP * NP);

  logic [CW-1:0] col, row;
  logic [PW-1:0] p;
  logic [IW-1:0] idx;
  logic          last_col, last_row, active, start, wr, emit, fd;

  always_comb begin
    p        = PW'(int'(col) / POOL);
    idx      = IW'((int'(row) / POOL) * NP + int'(col) / POOL);
    // Trailing rows/cols beyond the last full window are counted but ignored.
    active   = (int'(col) / POOL < NP) && (int'(row) / POOL < NP);
    start    = (int'(row) % POOL == 0) && (int'(col) % POOL == 0);
    last_col = (int'(col) == OUT_SIZE - 1);
    last_row = (int'(row) == OUT_SIZE - 1);
    wr       = i_valid && !i_clear && active;
    emit     = wr && (int'(row) % POOL == POOL - 1) && (int'(col) % POOL == POOL - 1);
    fd       = i_valid && !i_clear && last_col && last_row;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col          <= '0;
      row          <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      o_idx        <= '0;
    end else begin
      o_valid      <= emit;
      o_frame_done <= fd;
      if (emit) o_idx <= idx;
      if (i_clear) begin
        col <= '0;
        row <= '0;
      end else if (i_valid) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    pool_max_lane #(
      .DW(DW), .NP(NP), .PW(PW), .RELU_EN(RELU_EN)
    ) u_lane (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (i_clear),
      .i_wr    (wr),
      .i_start (start),
      .i_emit  (emit),
      .i_p     (p),
      .i_x     (i_data[c*DW +: DW]),
      .o_data  (o_data[c*DW +: DW])
    );
  end

endmodule

// File: tb/tb_relu_maxpool_stream.sv
// Scoreboard bench: four configurations of the pooler driven with directed
// frames; expected pulses are queued with their due cycle and checked by a monitor.
module tb_relu_maxpool_stream;

  typedef struct {
    int          cyc;
    bit          vld;
    logic [31:0] d;
    int          idx;
    bit          fd;
  } item_t;

  logic        clk = 1'b0;
  logic [3:0]  rst_n, clr, v;
  logic [31:0] d  [4];
  logic [31:0] od [4];
  logic [3:0]  ov, ofd;
  int          oi [4];

  logic [15:0] od_b, od_c, od_d;
  logic [1:0]  oi_a, oi_b, oi_c, oi_d;

  item_t q[4][$];
  int    cyc = 0;
  int    n_vec = 0, n_bad = 0;
  bit    chk_rst = 0, chk_end = 0;

  always #5 clk = ~clk;

  // A: 2 channels, ReLU on. B: ReLU off. C: 5x5 trailing. D: POOL=1 pass-through.
  relu_maxpool_stream #(.DW(16), .OUT_SIZE(4), .POOL(2), .CHANNELS(2), .RELU_EN(1'b1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_clear(clr[0]), .i_valid(v[0]), .i_data(d[0]),
    .o_valid(ov[0]), .o_data(od[0]), .o_idx(oi_a), .o_frame_done(ofd[0]));
  relu_maxpool_stream #(.DW(16), .OUT_SIZE(4), .POOL(2), .CHANNELS(1), .RELU_EN(1'b0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_clear(clr[1]), .i_valid(v[1]), .i_data(d[1][15:0]),
    .o_valid(ov[1]), .o_data(od_b), .o_idx(oi_b), .o_frame_done(ofd[1]));
  relu_maxpool_stream #(.DW(16), .OUT_SIZE(5), .POOL(2), .CHANNELS(1), .RELU_EN(1'b1)) u_c (
    .i_clk(clk), .i_rst_n(rst_n[2]), .i_clear(clr[2]), .i_valid(v[2]), .i_data(d[2][15:0]),
    .o_valid(ov[2]), .o_data(od_c), .o_idx(oi_c), .o_frame_done(ofd[2]));
  relu_maxpool_stream #(.DW(16), .OUT_SIZE(2), .POOL(1), .CHANNELS(1), .RELU_EN(1'b1)) u_d (
    .i_clk(clk), .i_rst_n(rst_n[3]), .i_clear(clr[3]), .i_valid(v[3]), .i_data(d[3][15:0]),
    .o_valid(ov[3]), .o_data(od_d), .o_idx(oi_d), .o_frame_done(ofd[3]));

  assign od[1] = {16'h0, od_b};
  assign od[2] = {16'h0, od_c};
  assign od[3] = {16'h0, od_d};
  assign oi[0] = int'(oi_a);
  assign oi[1] = int'(oi_b);
  assign oi[2] = int'(oi_c);
  assign oi[3] = int'(oi_d);

  always @(negedge clk) cyc <= cyc + 1;

  // Monitor: every output pulse must match the head of its queue, on its due cycle.
  always @(negedge clk) begin
    item_t it;
    for (int u = 0; u < 4; u++) begin
      if (chk_rst) begin
        n_vec++;
        if (ov[u] || ofd[u] || od[u] != 0 || oi[u] != 0) begin
          n_bad++;
          $display("FAIL reset_state dut%0d: got v=%0b fd=%0b d=%h idx=%0d, want all zero",
                   u, ov[u], ofd[u], od[u], oi[u]);
        end
      end
      if (chk_end) begin
        n_vec++;
        if (q[u].size() != 0) begin
          n_bad++;
          $display("FAIL drain dut%0d: %0d expected pulses never seen, want 0", u, q[u].size());
        end
      end
      if (!chk_rst && (ov[u] || ofd[u])) begin
        n_vec++;
        if (q[u].size() == 0) begin
          n_bad++;
          $display("FAIL unexpected dut%0d cyc=%0d: got v=%0b fd=%0b d=%h idx=%0d, want no pulse",
                   u, cyc, ov[u], ofd[u], od[u], oi[u]);
        end else begin
          it = q[u].pop_front();
          if (it.cyc != cyc || it.vld != ov[u] || it.fd != ofd[u] ||
              (it.vld && (it.d != od[u] || it.idx != oi[u]))) begin
            n_bad++;
            $display("FAIL out dut%0d: got cyc=%0d v=%0b d=%h idx=%0d fd=%0b, want cyc=%0d v=%0b d=%h idx=%0d fd=%0b",
                     u, cyc, ov[u], od[u], oi[u], ofd[u], it.cyc, it.vld, it.d, it.idx, it.fd);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pix(input int u, input logic [31:0] x, input bit ev,
                     input logic [31:0] ed, input int ei, input bit efd);
    item_t it;
    v[u] = 1'b1;
    d[u] = x;
    if (ev || efd) begin
      it.cyc = cyc + 1; it.vld = ev; it.d = ed; it.idx = ei; it.fd = efd;
      q[u].push_back(it);
    end
    @(posedge clk); #1;
    v[u] = 1'b0;
  endtask

  int e_pos4 [4] = '{5, 7, 13, 15};
  int e_c0   [4] = '{6, 8, 14, 16};
  int e_c1   [4] = '{16, 14, 8, 6};

  // Frame on A: ch0 = 1..16, ch1 = 16..1; neg replaces every pixel with -5.
  task automatic frame_a(input bit gaps, input bit neg);
    bit ev; logic [31:0] ed, x; int ei;
    for (int k = 0; k < 16; k++) begin
      ev = 0; ed = '0; ei = 0;
      for (int j = 0; j < 4; j++)
        if (k == e_pos4[j]) begin
          ev = 1; ei = j;
          ed = neg ? 32'h0 : {16'(e_c1[j]), 16'(e_c0[j])};
        end
      x = neg ? 32'hFFFB_FFFB : {16'(16 - k), 16'(k + 1)};
      if (gaps) idle($urandom_range(0, 3));
      pix(0, x, ev, ed, ei, k == 15);
    end
  endtask

  // First seven pixels of a frame on A; pixel 6 completes window 0.
  task automatic partial_a();
    for (int k = 0; k < 7; k++)
      pix(0, {16'(16 - k), 16'(k + 1)}, k == 5, {16'd16, 16'd6}, 0, 1'b0);
  endtask

  int mix   [16] = '{-3, -7, -20, -20, -1, -9, -20, -20, -20, -20, -20, -20, -20, -20, -20, -20};
  int e_mix [4]  = '{-1, -20, -20, -20};
  int e_pos5 [4] = '{6, 8, 16, 18};
  int e5     [4] = '{7, 9, 17, 19};
  int dat1   [4] = '{3, -4, 0, 7};
  int e1     [4] = '{3, 0, 0, 7};

  initial begin
    bit ev; logic [31:0] ed; int ei;
    rst_n = '0; clr = '0; v = '0;
    for (int u = 0; u < 4; u++) d[u] = '0;
    #2 chk_rst = 1;
    @(negedge clk); #1 chk_rst = 0;
    rst_n = '1;
    @(posedge clk); #1;

    frame_a(1'b0, 1'b0);
    frame_a(1'b0, 1'b1);
    frame_a(1'b1, 1'b0);
    frame_a(1'b1, 1'b0);

    partial_a();
    clr[0] = 1'b1; v[0] = 1'b1; d[0] = 32'h7777_7777;
    @(posedge clk); #1;
    clr[0] = 1'b0; v[0] = 1'b0;
    idle(2);
    frame_a(1'b0, 1'b0);

    partial_a();
    rst_n[0] = 1'b0;
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    idle(1);
    frame_a(1'b0, 1'b0);

    for (int k = 0; k < 16; k++) begin
      ev = 0; ei = 0;
      for (int j = 0; j < 4; j++) if (k == e_pos4[j]) begin ev = 1; ei = j; end
      pix(1, 32'h0000_FFFB, ev, 32'h0000_FFFB, ei, k == 15);
    end
    for (int k = 0; k < 16; k++) begin
      ev = 0; ei = 0; ed = '0;
      for (int j = 0; j < 4; j++)
        if (k == e_pos4[j]) begin ev = 1; ei = j; ed = {16'h0, 16'(e_mix[j])}; end
      pix(1, {16'h0, 16'(mix[k])}, ev, ed, ei, k == 15);
    end

    for (int k = 0; k < 25; k++) begin
      ev = 0; ei = 0; ed = '0;
      for (int j = 0; j < 4; j++)
        if (k == e_pos5[j]) begin ev = 1; ei = j; ed = {16'h0, 16'(e5[j])}; end
      pix(2, {16'h0, 16'(k + 1)}, ev, ed, ei, k == 24);
    end

    for (int k = 0; k < 4; k++)
      pix(3, {16'h0, 16'(dat1[k])}, 1'b1, {16'h0, 16'(e1[k])}, k, k == 3);

    idle(4);
    chk_end = 1;
    @(negedge clk); #1 chk_end = 0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/relu_maxpool_stream.md
Name: relu_maxpool_stream

Overview:
- Streaming ReLU plus max-pool stage that replaces the fixed 2x2 ReLU/maxpool array built around the PE.
- Consumes one raster-ordered convolution result per valid cycle, for CHANNELS parallel channels.
- Keeps a single row of partial maxima and emits pooled results in raster order with a fixed 1-cycle latency.
- Generalises pool size, feature-map width/height, channel count and ReLU enable; supports back-to-back frames with no per-pool enable/clean fan-out.

Parameters:
- DW, 16, signed data width per channel.
- OUT_SIZE, 4, conv output width = height (pixels per row/rows per frame).
- POOL, 2, pool window = stride (POOL x POOL, non-overlapping); 1 = pass-through.
- CHANNELS, 1, parallel channels sharing one pixel stream.
- RELU_EN, 1, 1 = clamp negatives to 0 before pooling; 0 = signed max only.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_clear  in  1  synchronous frame abort: zero counters and partials.
- i_valid  in  1  input pixel valid.
- i_data  in  CHANNELS*DW  channel c at [c*DW +: DW], signed.
- o_valid  out  1  pooled output valid (1-cycle pulse per result).
- o_data  out  CHANNELS*DW  pooled result, same packing.
- o_idx  out  clog2((OUT_SIZE/POOL)**2)  raster index of the pooled result in the frame.
- o_frame_done  out  1  1-cycle pulse after the last input pixel of a frame.

Behaviour:
- Reset (i_rst_n=0, asynchronous): o_valid=0, o_data=0, o_idx=0, o_frame_done=0; row/col counters 0; all partials 0.
- Input stream and counters:
  - Counters col (0..OUT_SIZE-1) and row (0..OUT_SIZE-1) advance only on i_valid.
  - i_valid may drop for any number of cycles; state holds.
- ReLU: x' = (RELU_EN && x<0) ? 0 : x, per channel. All compares are signed DW-bit; no width growth.
- Pool window mapping:
  - Pool column p = col/POOL; active only when p < OUT_SIZE/POOL and row/POOL < OUT_SIZE/POOL.
  - Pixels in trailing columns/rows when OUT_SIZE%POOL != 0 are ignored (floor semantics), but are still counted.
- Partial update, on an active valid pixel:
  - row%POOL==0 and col%POOL==0: partial[p] <= x' (overwrite, which starts a new window).
  - Otherwise: partial[p] <= max(partial[p], x').
- Emit:
  - Condition: active pixel with row%POOL==POOL-1 and col%POOL==POOL-1.
  - Next cycle: o_valid=1, o_data=max(partial[p],x'), o_idx=(row/POOL)*(OUT_SIZE/POOL)+p.
  - Latency is exactly 1 cycle from the completing input. Throughput is one pixel per cycle, with no backpressure.
  - POOL=1: every pixel emits x' after 1 cycle.
- o_idx holds its last value between pulses. o_data holds its last value when o_valid=0.
- Frame end:
  - On the valid pixel with row=col=OUT_SIZE-1, both counters wrap to 0.
  - o_frame_done pulses the next cycle, coincident with the final o_valid when OUT_SIZE%POOL==0.
  - The next frame may start that same next cycle.
- i_clear:
  - Has priority over i_valid in the same cycle; that pixel is dropped.
  - Clears counters and partials; o_valid and o_frame_done forced 0 next cycle.
- Reset mid-frame: all partial results are discarded; the next valid pixel is treated as (0,0).
- Storage: partials held in registers (OUT_SIZE/POOL)*CHANNELS*DW; no RAM inference required.

Decomposition:
- Shared package: DW default, clog2 helper function, signed max function, CHANNELS packing macro/localparams.
- One natural sub-module: pool_max_lane (one channel). It holds the partial row, the ReLU and the compare, and is instantiated CHANNELS times by generate. Counters, emit logic and o_idx stay in the top.

Test Plan:
- Basic 2x2 pool (OUT_SIZE=4, POOL=2, RELU_EN=1), i_valid continuous, data 1..16 raster -> o_data 6, 8, 14, 16 with o_idx 0..3, each 1 cycle after pixels 6, 8, 14, 16; o_frame_done 1 cycle after pixel 16.
- ReLU mode: all pixels -5, RELU_EN=1 -> four outputs of 0. Same stream with RELU_EN=0 -> four outputs of -5. Mixed window {-3,-7,-1,-9} with RELU_EN=0 -> -1.
- Trailing pixels: OUT_SIZE=5, POOL=2, data 1..25 -> outputs 7, 9, 17, 19; no output for row 4 or column 4; o_frame_done after pixel 25.
- Gaps and back-to-back frames: random 0-3 idle cycles between pixels over two consecutive frames of 1..16 -> identical 6, 8, 14, 16 sequence twice; no stale partial leaks into frame 2.
- Multichannel, CHANNELS=2: ch0 = 1..16, ch1 = 16..1 -> ch0 {6,8,14,16}, ch1 {16,14,8,6} in the same pulses.
- Abort: i_clear after pixel 7 (also i_rst_n low after pixel 7 in a separate run), then a fresh 1..16 frame -> exactly {6,8,14,16} with o_idx 0..3; no output at the abort cycle.
